// File: rtl/fpmultiply_system.sv
// fpmultiply_system
// -----------------------------------------------------------------------------
// Pipelined IEEE-754 single-precision multiplier with round-to-nearest-even.
// It accepts one operand pair per clock and returns the product plus exception
// flags a fixed LATENCY (3) cycles after the operands are sampled. There are no
// stalls, and every token moves through the pipeline on its own.
//
// Pipeline:
//   input regs : capture reg_A/reg_B on a clk edge where in_valid=1
//   S1         : decode each operand (zero/subnormal/normal/Inf/NaN), result sign
//   S2         : 24x24 mantissa product, biased exponent, special-result tag
//   S3         : normalize, RNE round, overflow/underflow, register out/flags
//
// Ports:
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous, active-high reset
//   reg_A      in  32   operand A (IEEE-754 single)
//   reg_B      in  32   operand B (IEEE-754 single)
//   in_valid   in   1   qualifies reg_A/reg_B
//   out        out 32   rounded product (holds while out_valid=0)
//   out_valid  out  1   one-cycle pulse per result
//   flags      out  4   {invalid, overflow, underflow, inexact}
//
// Configuration macro FPMUL_DENORM_EN:
//   defined   -> gradual underflow (subnormal inputs pre-normalized with a
//                leading-zero count, tiny results denormalized then rounded)
//   undefined -> flush-to-zero (subnormal inputs read as zero, tiny results
//                become signed zero with underflow and inexact)
// -----------------------------------------------------------------------------
module fpmultiply_system #(
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] reg_A,
  input  logic [31:0] reg_B,
  input  logic        in_valid,
  output logic [31:0] out,
  output logic        out_valid,
  output logic [3:0]  flags
);

  // Special-result tag carried from S2 into S3.
  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_NAN  = 2'd1;
  localparam logic [1:0] TAG_INF  = 2'd2;
  localparam logic [1:0] TAG_ZERO = 2'd3;

  // Operand class bits: {zero, inf, nan, snan}.
  function automatic logic [3:0] classify(input logic [30:0] x);
    logic exp_max;
    logic exp_min;
    logic man_zero;
    exp_max  = &x[30:23];
    exp_min  = ~|x[30:23];
    man_zero = ~|x[22:0];
`ifdef FPMUL_DENORM_EN
    classify[3] = exp_min & man_zero;
`else
    // Flush-to-zero: a subnormal operand counts as a signed zero.
    classify[3] = exp_min;
`endif
    classify[2] = exp_max & man_zero;
    classify[1] = exp_max & ~man_zero;
    classify[0] = exp_max & ~man_zero & ~x[22];
  endfunction

`ifdef FPMUL_DENORM_EN
  // Leading-zero count of a 24-bit significand (24 when it is all zero).
  function automatic logic [4:0] lzc24(input logic [23:0] v);
    lzc24 = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (v[i]) lzc24 = 5'(23 - i);
    end
  endfunction
`endif

  // Valid bit per register level; the top bit is out_valid itself.
  logic [LATENCY:0] stage_valid;

  logic [31:0] a_in;
  logic [31:0] b_in;

  logic        s1_sign;
  logic [3:0]  s1_cls_a;
  logic [3:0]  s1_cls_b;
  logic [23:0] s1_sig_a;
  logic [23:0] s1_sig_b;
  logic [7:0]  s1_exp_a;
  logic [7:0]  s1_exp_b;

  logic [23:0]       norm_sig_a;
  logic [23:0]       norm_sig_b;
  logic signed [9:0] norm_exp_a;
  logic signed [9:0] norm_exp_b;
  logic [47:0]       prod_c;
  logic signed [9:0] exp_c;
  logic [1:0]        tag_c;
  logic              invalid_c;
`ifdef FPMUL_DENORM_EN
  logic [4:0]        lz_a;
  logic [4:0]        lz_b;
`endif

  logic              s2_sign;
  logic [47:0]       s2_prod;
  logic signed [9:0] s2_exp;
  logic [1:0]        s2_tag;
  logic              s2_invalid;

  logic [47:0]       norm_prod;
  logic signed [9:0] e1;
  logic [47:0]       aligned;
  logic [23:0]       rnd_sig;
  logic              guard_bit;
  logic              round_bit;
  logic              sticky_bit;
  logic              round_up;
  logic [24:0]       round_sum;
  logic signed [9:0] e_base;
  logic [32:0]       pack_sum;
  logic signed [9:0] e_final;
  logic              inexact;
`ifdef FPMUL_DENORM_EN
  logic              tiny;
  logic signed [9:0] under_by;
  logic [5:0]        denorm_sh;
  logic [95:0]       wide;
`endif

  logic [31:0] res_out;
  logic [3:0]  res_flags;

  // The valid shift register advances every cycle so that bubbles appear at
  // the output exactly LATENCY cycles after they enter. Reset drops all
  // in-flight tokens.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_valid <= '0;
    end else begin
      stage_valid <= {stage_valid[LATENCY-1:0], in_valid};
    end
  end

  assign out_valid = stage_valid[LATENCY];

  // Operand capture. Data registers only load for real tokens; downstream
  // stages ignore their contents when the matching valid bit is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_in <= '0;
      b_in <= '0;
    end else if (in_valid) begin
      a_in <= reg_A;
      b_in <= reg_B;
    end
  end

  // S1: classify both operands and expose significands with the hidden bit.
  // Subnormals get hidden bit 0 and effective exponent 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_sign  <= 1'b0;
      s1_cls_a <= '0;
      s1_cls_b <= '0;
      s1_sig_a <= '0;
      s1_sig_b <= '0;
      s1_exp_a <= '0;
      s1_exp_b <= '0;
    end else if (stage_valid[0]) begin
      s1_sign  <= a_in[31] ^ b_in[31];
      s1_cls_a <= classify(a_in[30:0]);
      s1_cls_b <= classify(b_in[30:0]);
      s1_sig_a <= {|a_in[30:23], a_in[22:0]};
      s1_sig_b <= {|b_in[30:23], b_in[22:0]};
      s1_exp_a <= (a_in[30:23] == 8'd0) ? 8'd1 : a_in[30:23];
      s1_exp_b <= (b_in[30:23] == 8'd0) ? 8'd1 : b_in[30:23];
    end
  end

  // S2 datapath: pre-normalize subnormals so the product always has its
  // leading one in bit 47 or 46, then multiply and form eA + eB - 127.
  always_comb begin
`ifdef FPMUL_DENORM_EN
    lz_a       = lzc24(s1_sig_a);
    lz_b       = lzc24(s1_sig_b);
    norm_sig_a = s1_sig_a << lz_a;
    norm_sig_b = s1_sig_b << lz_b;
    norm_exp_a = $signed({2'b00, s1_exp_a}) - $signed({5'b00000, lz_a});
    norm_exp_b = $signed({2'b00, s1_exp_b}) - $signed({5'b00000, lz_b});
`else
    norm_sig_a = s1_sig_a;
    norm_sig_b = s1_sig_b;
    norm_exp_a = $signed({2'b00, s1_exp_a});
    norm_exp_b = $signed({2'b00, s1_exp_b});
`endif
    prod_c = 48'(norm_sig_a) * 48'(norm_sig_b);
    exp_c  = norm_exp_a + norm_exp_b - 10'sd127;
  end

  // S2 special-operand resolution in priority order: NaN or Inf*0 first,
  // then Inf, then zero. Only signaling NaNs and Inf*0 raise invalid.
  always_comb begin
    tag_c     = TAG_NONE;
    invalid_c = 1'b0;
    if (s1_cls_a[1] | s1_cls_b[1] | (s1_cls_a[2] & s1_cls_b[3]) |
        (s1_cls_a[3] & s1_cls_b[2])) begin
      tag_c     = TAG_NAN;
      invalid_c = s1_cls_a[0] | s1_cls_b[0] | (s1_cls_a[2] & s1_cls_b[3]) |
                  (s1_cls_a[3] & s1_cls_b[2]);
    end else if (s1_cls_a[2] | s1_cls_b[2]) begin
      tag_c = TAG_INF;
    end else if (s1_cls_a[3] | s1_cls_b[3]) begin
      tag_c = TAG_ZERO;
    end
  end

  // S2 register stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_sign    <= 1'b0;
      s2_prod    <= '0;
      s2_exp     <= '0;
      s2_tag     <= TAG_NONE;
      s2_invalid <= 1'b0;
    end else if (stage_valid[1]) begin
      s2_sign    <= s1_sign;
      s2_prod    <= prod_c;
      s2_exp     <= exp_c;
      s2_tag     <= tag_c;
      s2_invalid <= invalid_c;
    end
  end

  // S3 datapath: put the leading one at bit 47, optionally shift tiny values
  // down into the subnormal range, then round to nearest even. The rounded
  // significand is added onto (exponent - 1) << 23 so that a rounding carry
  // bumps the exponent for free, and a subnormal that rounds up to 2^23
  // becomes the smallest normal.
  always_comb begin
    norm_prod = s2_prod[47] ? s2_prod : (s2_prod << 1);
    e1        = s2_exp + (s2_prod[47] ? 10'sd1 : 10'sd0);
`ifdef FPMUL_DENORM_EN
    tiny      = (e1 <= 10'sd0);
    under_by  = 10'sd1 - e1;
    denorm_sh = 6'd0;
    if (tiny) begin
      denorm_sh = (under_by > 10'sd63) ? 6'd63 : under_by[5:0];
    end
    wide       = {norm_prod, 48'd0} >> denorm_sh;
    aligned    = wide[95:48];
    sticky_bit = (|aligned[21:0]) | (|wide[47:0]);
    e_base     = tiny ? 10'sd0 : (e1 - 10'sd1);
`else
    aligned    = norm_prod;
    sticky_bit = |aligned[21:0];
    e_base     = e1 - 10'sd1;
`endif
    rnd_sig   = aligned[47:24];
    guard_bit = aligned[23];
    round_bit = aligned[22];
    inexact   = guard_bit | round_bit | sticky_bit;
    round_up  = guard_bit & (round_bit | sticky_bit | rnd_sig[0]);
    round_sum = {1'b0, rnd_sig} + {24'd0, round_up};
    pack_sum  = {e_base, 23'd0} + {8'd0, round_sum};
    e_final   = pack_sum[32:23];
  end

  // S3 result selection: specials bypass the arithmetic, otherwise apply
  // overflow and the configured underflow handling.
  always_comb begin
    res_out   = {s2_sign, 31'd0};
    res_flags = 4'd0;
    case (s2_tag)
      TAG_NAN: begin
        res_out   = 32'h7FC0_0000;
        res_flags = {s2_invalid, 3'b000};
      end
      TAG_INF: begin
        res_out = {s2_sign, 8'hFF, 23'd0};
      end
      TAG_ZERO: begin
        res_out = {s2_sign, 31'd0};
      end
      default: begin
        if (e_final >= 10'sd255) begin
          res_out   = {s2_sign, 8'hFF, 23'd0};
          res_flags = 4'b0101;
`ifdef FPMUL_DENORM_EN
        end else begin
          res_out   = {s2_sign, e_final[7:0], pack_sum[22:0]};
          res_flags = {2'b00, tiny & inexact, inexact};
        end
`else
        end else if (e_final <= 10'sd0) begin
          res_out   = {s2_sign, 31'd0};
          res_flags = 4'b0011;
        end else begin
          res_out   = {s2_sign, e_final[7:0], pack_sum[22:0]};
          res_flags = {3'b000, inexact};
        end
`endif
      end
    endcase
  end

  // Output registers load only for valid tokens, so out and flags hold their
  // last values between results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out   <= '0;
      flags <= '0;
    end else if (stage_valid[LATENCY-1]) begin
      out   <= res_out;
      flags <= res_flags;
    end
  end

endmodule

// File: tb/tb_fpmultiply_system.sv
// tb_fpmultiply_system
// -----------------------------------------------------------------------------
// Directed bench for fpmultiply_system. A value-level reference model computes
// the exact product as an integer times a power of two and rounds it to the
// single-precision grid; a scoreboard checks out_valid/out/flags every cycle.
// Hand-computed literals pin the reference model. Honours FPMUL_DENORM_EN.
// -----------------------------------------------------------------------------
module tb_fpmultiply_system;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] reg_A;
  logic [31:0] reg_B;
  logic        in_valid;
  logic [31:0] out;
  logic        out_valid;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;

  logic [31:0] last_out   = '0;
  logic [3:0]  last_flags = '0;

  typedef struct packed {
    int          due;
    logic [31:0] res;
    logic [3:0]  flg;
  } token_t;

  token_t sb[$];
  token_t head;

  fpmultiply_system #(.LATENCY(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .reg_A     (reg_A),
    .reg_B     (reg_B),
    .in_valid  (in_valid),
    .out       (out),
    .out_valid (out_valid),
    .flags     (flags)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Edge counter used to schedule when each result is due.
  always @(posedge clk) edge_cnt++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: value = ma*mb*2^(xa+xb). Choose the output quantum 2^q from
  // the position of the leading one, round the integer quotient to nearest
  // even, then encode.
  function automatic logic [35:0] model_mul(input logic [31:0] a, input logic [31:0] b);
    logic         sr;
    int           ea, eb, e_sum, msb, q, shift, ebias;
    logic [22:0]  fa, fb;
    logic         a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, inv;
    logic [127:0] ma, mb, p, k, rem, half, one;
    logic         tiny, inexact, up, uf;
    one = 128'd1;
    sr  = a[31] ^ b[31];
    ea  = a[30:23];
    eb  = b[30:23];
    fa  = a[22:0];
    fb  = b[22:0];
    a_nan = (ea == 255) && (fa != 0);
    b_nan = (eb == 255) && (fb != 0);
    a_inf = (ea == 255) && (fa == 0);
    b_inf = (eb == 255) && (fb == 0);
`ifdef FPMUL_DENORM_EN
    a_zero = (ea == 0) && (fa == 0);
    b_zero = (eb == 0) && (fb == 0);
`else
    a_zero = (ea == 0);
    b_zero = (eb == 0);
`endif
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      inv = (a_nan && !fa[22]) || (b_nan && !fb[22]) || (a_inf && b_zero) || (a_zero && b_inf);
      return {32'h7FC00000, inv, 3'b000};
    end
    if (a_inf || b_inf) return {sr, 8'hFF, 23'd0, 4'h0};
    if (a_zero || b_zero) return {sr, 31'd0, 4'h0};
    ma    = (ea == 0) ? {105'd0, fa} : {104'd0, 1'b1, fa};
    mb    = (eb == 0) ? {105'd0, fb} : {104'd0, 1'b1, fb};
    e_sum = ((ea == 0) ? 1 : ea) - 150 + ((eb == 0) ? 1 : eb) - 150;
    p     = ma * mb;
    msb   = 0;
    for (int i = 0; i < 128; i++) if (p[i]) msb = i;
    q     = msb + e_sum - 23;
    tiny  = (q < -149);
`ifdef FPMUL_DENORM_EN
    if (q < -149) q = -149;
`endif
    shift = q - e_sum;
    if (shift >= 100) begin
      k = '0;
      inexact = 1'b1;
    end else if (shift <= 0) begin
      k = p << (-shift);
      inexact = 1'b0;
    end else begin
      k    = p >> shift;
      rem  = p & ((one << shift) - one);
      half = one << (shift - 1);
      up   = (rem > half) || ((rem == half) && k[0]);
      inexact = (rem != 0);
      k = k + {127'd0, up};
    end
    if (k == (one << 24)) begin
      k = k >> 1;
      q = q + 1;
    end
    ebias = (k >= (one << 23)) ? q + 150 : 0;
    if (ebias >= 255) return {sr, 8'hFF, 23'd0, 4'b0101};
`ifdef FPMUL_DENORM_EN
    uf = tiny && inexact;
    return {sr, 8'(ebias), k[22:0], 2'b00, uf, inexact};
`else
    uf = tiny;
    if (ebias <= 0) return {sr, 31'd0, 4'b0011};
    return {sr, 8'(ebias), k[22:0], 2'b00, uf & 1'b0, inexact};
`endif
  endfunction

  // Pin the reference model with a hand-computed expectation.
  task automatic pinModel(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_out, input logic [3:0] exp_flags);
    logic [35:0] r;
    r = model_mul(a, b);
    checkOutput("model out", r[35:4], exp_out);
    checkOutput("model flags", {28'd0, r[3:0]}, {28'd0, exp_flags});
  endtask

  // Drive one operand pair; it is sampled on the next edge and due 3 edges later.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    logic [35:0] r;
    token_t t;
    @(posedge clk);
    #2;
    reg_A    = a;
    reg_B    = b;
    in_valid = 1'b1;
    r = model_mul(a, b);
    t.due = edge_cnt + 4;
    t.res = r[35:4];
    t.flg = r[3:0];
    sb.push_back(t);
  endtask

  task automatic applyBubble();
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    reg_A    = $urandom;
    reg_B    = $urandom;
  endtask

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("reset out", out, 32'd0);
      checkOutput("reset flags", {28'd0, flags}, 32'd0);
      last_out   = '0;
      last_flags = '0;
    end else if (sb.size() != 0 && sb[0].due == edge_cnt) begin
      head = sb.pop_front();
      checkOutput("out_valid pulse", {31'd0, out_valid}, 32'd1);
      checkOutput("out", out, head.res);
      checkOutput("flags", {28'd0, flags}, {28'd0, head.flg});
      last_out   = head.res;
      last_flags = head.flg;
    end else begin
      checkOutput("out_valid idle", {31'd0, out_valid}, 32'd0);
      checkOutput("out hold", out, last_out);
      checkOutput("flags hold", {28'd0, flags}, {28'd0, last_flags});
    end
  end

  logic [31:0] extra_a [12] = '{32'h7FA00000, 32'h7FC00001, 32'hFF800000, 32'h80000000,
                                32'h00000001, 32'h3F800001, 32'h00800001, 32'h7F000000,
                                32'h3FFFFFFF, 32'h00400000, 32'h0DA24260, 32'h3F800000};
  logic [31:0] extra_b [12] = '{32'h3F800000, 32'h40000000, 32'h40000000, 32'h40000000,
                                32'h4B000000, 32'h3F7FFFFF, 32'h3F000000, 32'h3F000000,
                                32'h3FFFFFFF, 32'h40800000, 32'h0DA24260, 32'h00000000};

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    reg_A    = '0;
    reg_B    = '0;

    // Pin the reference model against hand-computed values.
    pinModel(32'h40400000, 32'h40200000, 32'h40F00000, 4'b0000);
    pinModel(32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000);
    pinModel(32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000);
    pinModel(32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
    pinModel(32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
    pinModel(32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0101);
    pinModel(32'h7FA00000, 32'h3F800000, 32'h7FC00000, 4'b1000);
    pinModel(32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000);
`ifdef FPMUL_DENORM_EN
    pinModel(32'h00800000, 32'h3F000000, 32'h00400000, 4'b0000);
    pinModel(32'h00800001, 32'h3F000000, 32'h00400000, 4'b0011);
`else
    pinModel(32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011);
    pinModel(32'h00800001, 32'h3F000000, 32'h00000000, 4'b0011);
`endif

    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;

    // Single normal product, then bubbles.
    applyStimulus(32'h40400000, 32'h40200000);
    applyBubble();
    applyBubble();

    // Back-to-back tokens.
    applyStimulus(32'hC0000000, 32'h40400000);
    applyStimulus(32'h3FC00000, 32'h3FC00000);
    applyStimulus(32'h3F800001, 32'h3F800001);
    applyBubble();
    applyStimulus(32'h7F800000, 32'h00000000);
    applyStimulus(32'h7F7FFFFF, 32'h40000000);
    applyStimulus(32'h00800000, 32'h3F000000);
    applyBubble();

    // Further specials, subnormals, ties and underflow.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(extra_a[i], extra_b[i]);
      if (i % 4 == 3) applyBubble();
    end
    applyBubble();
    repeat (4) applyBubble();

    // Reset one cycle after two valid inputs: neither may emerge.
    applyStimulus(32'h40400000, 32'h40400000);
    applyStimulus(32'h40A00000, 32'h40A00000);
    @(posedge clk);
    #2;
    reset    = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #2;
    // Release and present a new pair on the same cycle.
    begin
      logic [35:0] r;
      token_t t;
      reset    = 1'b0;
      reg_A    = 32'h40400000;
      reg_B    = 32'h40200000;
      in_valid = 1'b1;
      r = model_mul(reg_A, reg_B);
      t.due = edge_cnt + 4;
      t.res = r[35:4];
      t.flg = r[3:0];
      sb.push_back(t);
    end
    applyBubble();

    // Drain with a bounded wait.
    for (int w = 0; w < 20 && sb.size() != 0; w++) begin
      @(negedge clk);
      #1;
    end
    checkOutput("scoreboard drained", sb.size(), 32'd0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
